pwm_multichannel_wb: RTL and testbench
======================================

# pwm_multichannel_wb

Wishbone-mapped, NUM_CH-channel PWM generator sharing one programmable-period counter, with double-buffered (glitch-free) edge positions, wrap-around pulses, per-channel polarity, rise/fall strobes and a period-wrap interrupt. It is the parametrised successor of the single-channel counter/one-shot-detector PWM in TOP_digital and sits directly on the user-project Wishbone slave bus. Its outputs drive the isolator-driver gate channels and the ramp-and-sample trigger.

## Interface
- NUM_CH, 4, channel count (1..8)
- WIDTH, 8, counter/edge width in bits (4..16)
- BASE_ADDRESS, 32'h3000_0000, start of the 0x50-byte register window
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  reset; synchronous, active-high
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write
- wbs_sel_i  in  4  byte-lane enables for writes
- wbs_adr_i, wbs_dat_i  in  32 each  address and write data
- wbs_ack_o  out  1  registered acknowledge
- wbs_dat_o  out  32  registered read data
- pwm_out  out  NUM_CH  PWM outputs after polarity
- rise_strobe, fall_strobe  out  NUM_CH each  one-cycle pulse when the count hits the active rise/fall position
- period_irq  out  1  one-cycle pulse on each counter wrap

## Operation
- Register map (byte offsets from BASE_ADDRESS):
  - 8*ch+0: RISE[ch]
  - 8*ch+4: FALL[ch]
  - 0x40: CTRL
  - 0x44: PERIOD
  - 0x48: STATUS
  - 0x4C: ID, reads 32'hAA553311
- Offsets below 0x40 that belong to a channel ch >= NUM_CH, and all other unmapped offsets in the window, read 0 and ignore writes.
- CTRL bits:
  - bit0 enable
  - bit1 immediate (1 = active regs track shadows every cycle)
  - bits[16+ch] invert pwm_out[ch]
  - all other bits read 0
- STATUS bit0 is the sticky wrap flag; writing 1 clears it (W1C). All other STATUS bits read 0.
- Writes honour wbs_sel_i per byte. RISE, FALL and PERIOD store only bits [WIDTH-1:0]; upper bits read 0.
- RISE, FALL and PERIOD are shadow registers. The counter and comparators use active copies.
  - Active copies load from the shadows on a wrap edge.
  - They also load every cycle while enable=0 or immediate=1.
- Counter: 0..PERIOD_active.
  - Next value is 0 when count >= PERIOD_active; otherwise count+1.
  - When enable=0 the counter is held at 0.
- Raw channel level from the active values r (rise) and f (fall):
  - r<f: high when r <= count < f
  - r==f: constant low
  - r>f (wrap-around): high when count >= r or count < f
- pwm_out[ch] = raw XOR invert[ch]. When enable=0, raw is forced low.
- Strobes fire only while enable=1.
- Wrap event: enable=1 and count >= PERIOD_active. It sets STATUS bit0 and pulses period_irq.
- Simultaneous STATUS W1C and wrap: set wins.
- Shadow write on the same edge as a wrap: the active copy loads the pre-write value; the new value takes effect at the following wrap.
- Wishbone:
  - ack <= stb & cyc & !ack & (adr within the window).
  - Addresses outside the window are never acked.
  - A write commits on the edge that raises ack.
  - Read data is registered on that same edge and is valid while ack=1.
  - ack is a single cycle, so back-to-back requests see one idle cycle between acks.

## Timing
- Reset values:
  - all outputs 0; count 0
  - RISE, FALL, CTRL, STATUS shadows and actives 0
  - PERIOD = 2^WIDTH-1
  - ack 0, dat_o 0
- Reset asserted mid-period applies on the next edge and overrides any bus write in that cycle.
- pwm_out, strobes and period_irq are registered: they reflect the count value of the previous cycle, so latency is 1 cycle from the count.
- The output period is PERIOD+1 cycles. With PERIOD=0 the counter stays at 0 and period_irq is high every cycle.
- Shrinking PERIOD in immediate mode while count > new PERIOD wraps at the next edge.

## Test plan
- Basic PWM:
  - Stimulus: WIDTH=8, PERIOD=9, RISE0=2, FALL0=6, enable=1.
  - Required: pwm_out[0] high 4 of every 10 cycles; rise_strobe[0] and fall_strobe[0] are 4 cycles apart; period_irq every 10 cycles.
- Wrap-around and degenerate cases:
  - Stimulus: RISE1=8, FALL1=3, PERIOD=9; then RISE1=FALL1=5; then invert bit 17 set.
  - Required: 5-high/5-low with high spanning the wrap; then constant 0; then with bit 17 set, constant 1.
- Double buffering:
  - Stimulus: write FALL0=8 mid-period while immediate=0.
  - Required: the current period keeps the old width; the next period starts at count 0 with 6 high cycles. A write landing exactly on the wrap edge applies one period later.
- Bus behaviour:
  - Stimulus: read ID; write to BASE+0x50; write RISE0 with wbs_sel_i=4'b0001 and data 32'hFFFF_FF33.
  - Required: ID reads 32'hAA553311; no ack outside the window; RISE0 reads 32'h0000_0033; ack is a one-cycle pulse.
- STATUS and reset:
  - Stimulus: let a wrap occur, read STATUS, write 1 to STATUS; then assert wb_rst_i mid-period.
  - Required: STATUS reads 1 after the wrap and 0 after the W1C; after reset all outputs are 0 and PERIOD reads 2^WIDTH-1.
- Immediate mode:
  - Stimulus: immediate=1, count=7, write PERIOD=3.
  - Required: the counter wraps to 0 on the next edge; period_irq pulses once.

Source files
------------

// File: rtl/pwm_multichannel_wb.sv
// pwm_multichannel_wb
// NUM_CH-channel PWM generator on a Wishbone classic slave port. All channels
// share one counter running 0..PERIOD. Each channel has a rise and a fall edge
// position; rise > fall gives a pulse that spans the counter wrap. RISE, FALL
// and PERIOD are written into shadow registers and copied to the active set
// on a counter wrap, so a period in progress is never cut short. The copy also
// happens every cycle while disabled or in immediate mode.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wbs_stb_i/cyc_i/we_i      Wishbone classic request qualifiers
//   wbs_sel_i                 byte-lane enables for writes
//   wbs_adr_i, wbs_dat_i      byte address and write data
//   wbs_ack_o, wbs_dat_o      registered acknowledge and read data
//   pwm_out[NUM_CH]           PWM level after per-channel polarity
//   rise_strobe, fall_strobe  one-cycle pulse when count hits the edge position
//   period_irq                one-cycle pulse per counter wrap
//
// Register window (byte offsets): 8*ch+0 RISE, 8*ch+4 FALL, 0x40 CTRL,
// 0x44 PERIOD, 0x48 STATUS (bit0 sticky wrap, W1C), 0x4C ID.
module pwm_multichannel_wb #(
  parameter int          NUM_CH       = 4,
  parameter int          WIDTH        = 8,
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] rise_strobe,
  output logic [NUM_CH-1:0] fall_strobe,
  output logic              period_irq
);

  localparam logic [31:0] ID_VALUE     = 32'hAA55_3311;
  localparam logic [31:0] WINDOW_BYTES = 32'h0000_0050;
  // enable, immediate and one invert bit per implemented channel
  localparam logic [31:0] CTRL_MASK    = 32'h0000_0003 | (((32'h1 << NUM_CH) - 32'h1) << 16);
  localparam logic [4:0]  WORD_CTRL    = 5'h10;
  localparam logic [4:0]  WORD_PERIOD  = 5'h11;
  localparam logic [4:0]  WORD_STATUS  = 5'h12;
  localparam logic [4:0]  WORD_ID      = 5'h13;

  // shadow (bus-visible) registers
  logic [WIDTH-1:0]  r_rise_sh [NUM_CH];
  logic [WIDTH-1:0]  r_fall_sh [NUM_CH];
  logic [WIDTH-1:0]  r_period_sh;
  logic [31:0]       r_ctrl;
  logic              r_status;

  // active copies used by the counter and comparators
  logic [WIDTH-1:0]  r_rise_act [NUM_CH];
  logic [WIDTH-1:0]  r_fall_act [NUM_CH];
  logic [WIDTH-1:0]  r_period_act;
  logic [WIDTH-1:0]  r_count;

  logic              r_ack;
  logic [31:0]       r_dat;
  logic [NUM_CH-1:0] r_pwm;
  logic [NUM_CH-1:0] r_rise_stb;
  logic [NUM_CH-1:0] r_fall_stb;
  logic              r_irq;

  logic [31:0]       w_offset;
  logic              w_in_window;
  logic              w_req;
  logic              w_wr;
  logic [4:0]        w_word;
  logic [2:0]        w_ch;
  logic              w_is_fall;
  logic              w_chan_region;
  logic              w_enable;
  logic              w_immediate;
  logic              w_wrap;
  logic              w_load_act;
  logic              w_status_clr;
  logic [31:0]       w_rdata;
  logic [NUM_CH-1:0] w_raw;
  logic [NUM_CH-1:0] w_rise_hit;
  logic [NUM_CH-1:0] w_fall_hit;

  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // unsigned subtraction makes addresses below the base land far above the window
  assign w_offset      = wbs_adr_i - BASE_ADDRESS;
  assign w_in_window   = (w_offset < WINDOW_BYTES);
  assign w_req         = wbs_stb_i & wbs_cyc_i & ~r_ack & w_in_window;
  assign w_wr          = w_req & wbs_we_i;
  assign w_word        = w_offset[6:2];
  assign w_ch          = w_offset[5:3];
  assign w_is_fall     = w_offset[2];
  assign w_chan_region = ~w_offset[6];

  assign w_enable      = r_ctrl[0];
  assign w_immediate   = r_ctrl[1];
  assign w_wrap        = w_enable & (r_count >= r_period_act);
  assign w_load_act    = w_wrap | ~w_enable | w_immediate;
  assign w_status_clr  = w_wr & ~w_chan_region & (w_word == WORD_STATUS)
                         & wbs_sel_i[0] & wbs_dat_i[0];

  always_comb begin
    w_rdata = '0;
    if (w_chan_region) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (w_ch == 3'(ch)) begin
          w_rdata = w_is_fall ? 32'(r_fall_sh[ch]) : 32'(r_rise_sh[ch]);
        end
      end
    end else begin
      case (w_word)
        WORD_CTRL:   w_rdata = r_ctrl;
        WORD_PERIOD: w_rdata = 32'(r_period_sh);
        WORD_STATUS: w_rdata = {31'b0, r_status};
        WORD_ID:     w_rdata = ID_VALUE;
        default:     w_rdata = '0;
      endcase
    end
  end

  always_comb begin
    w_raw      = '0;
    w_rise_hit = '0;
    w_fall_hit = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (r_rise_act[ch] < r_fall_act[ch]) begin
        w_raw[ch] = (r_count >= r_rise_act[ch]) && (r_count < r_fall_act[ch]);
      end else if (r_rise_act[ch] > r_fall_act[ch]) begin
        // pulse spans the wrap
        w_raw[ch] = (r_count >= r_rise_act[ch]) || (r_count < r_fall_act[ch]);
      end
      w_rise_hit[ch] = (r_count == r_rise_act[ch]);
      w_fall_hit[ch] = (r_count == r_fall_act[ch]);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_rise_sh[ch] <= '0;
        r_fall_sh[ch] <= '0;
      end
      r_period_sh <= '1;
      r_ctrl      <= '0;
    end else if (w_wr) begin
      if (w_chan_region) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          if (w_ch == 3'(ch)) begin
            if (w_is_fall) begin
              r_fall_sh[ch] <= WIDTH'(f_merge(32'(r_fall_sh[ch]), wbs_dat_i, wbs_sel_i));
            end else begin
              r_rise_sh[ch] <= WIDTH'(f_merge(32'(r_rise_sh[ch]), wbs_dat_i, wbs_sel_i));
            end
          end
        end
      end else begin
        case (w_word)
          WORD_CTRL:   r_ctrl      <= f_merge(r_ctrl, wbs_dat_i, wbs_sel_i) & CTRL_MASK;
          WORD_PERIOD: r_period_sh <= WIDTH'(f_merge(32'(r_period_sh), wbs_dat_i, wbs_sel_i));
          default: ;
        endcase
      end
    end
  end

  // a wrap on the same edge as a clear keeps the flag set
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_status <= 1'b0;
    end else if (w_wrap) begin
      r_status <= 1'b1;
    end else if (w_status_clr) begin
      r_status <= 1'b0;
    end
  end

  // actives sample the shadows before any write on this edge lands
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_rise_act[ch] <= '0;
        r_fall_act[ch] <= '0;
      end
      r_period_act <= '1;
      r_count      <= '0;
    end else begin
      if (w_load_act) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          r_rise_act[ch] <= r_rise_sh[ch];
          r_fall_act[ch] <= r_fall_sh[ch];
        end
        r_period_act <= r_period_sh;
      end
      if (!w_enable || (r_count >= r_period_act)) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_pwm      <= '0;
      r_rise_stb <= '0;
      r_fall_stb <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_pwm      <= (w_raw & {NUM_CH{w_enable}}) ^ r_ctrl[16 +: NUM_CH];
      r_rise_stb <= w_rise_hit & {NUM_CH{w_enable}};
      r_fall_stb <= w_fall_hit & {NUM_CH{w_enable}};
      r_irq      <= w_wrap;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_req ? w_rdata : 32'h0;
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign pwm_out     = r_pwm;
  assign rise_strobe = r_rise_stb;
  assign fall_strobe = r_fall_stb;
  assign period_irq  = r_irq;

endmodule

// File: tb/tb_pwm_multichannel_wb.sv
module tb_pwm_multichannel_wb;
  localparam int          NCH  = 4;
  localparam int          W    = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] WMASK = 32'((1 << W) - 1);
  localparam logic [31:0] CMASK = 32'h3 | (32'((1 << NCH) - 1) << 16);

  logic clk = 1'b0;
  logic rst, stb, cyc, we;
  logic [3:0] sel;
  logic [31:0] adr, dat_i;
  logic ack;
  logic [31:0] dat_o;
  logic [NCH-1:0] pwm, rs, fs;
  logic irq;

  pwm_multichannel_wb #(.NUM_CH(NCH), .WIDTH(W), .BASE_ADDRESS(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i),
    .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .pwm_out(pwm), .rise_strobe(rs), .fall_strobe(fs), .period_irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  // reference model state
  int m_rise[NCH], m_fall[NCH], m_rise_a[NCH], m_fall_a[NCH];
  int m_per, m_per_a, m_cnt;
  logic [31:0] m_ctrl;
  logic m_status;
  logic [NCH-1:0] m_pwm, m_rs, m_fs;
  logic m_irq, m_ack;
  logic [31:0] m_dat;

  int q0[$];
  int q1[$];
  int acc0 = 0;
  int acc1 = 0;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_rise[c] = 0; m_fall[c] = 0; m_rise_a[c] = 0; m_fall_a[c] = 0;
    end
    m_per = (1 << W) - 1; m_per_a = m_per; m_cnt = 0;
    m_ctrl = 0; m_status = 0;
    m_pwm = 0; m_rs = 0; m_fs = 0; m_irq = 0; m_ack = 0; m_dat = 0;
  endtask

  function automatic logic [31:0] model_read(input int off);
    if (off < 64) begin
      int c = off / 8;
      if (c >= NCH) return 32'h0;
      return (off % 8 < 4) ? 32'(m_rise[c]) : 32'(m_fall[c]);
    end
    case (off / 4)
      16: return m_ctrl;
      17: return 32'(m_per);
      18: return {31'b0, m_status};
      19: return 32'hAA55_3311;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d, input logic [31:0] m);
    return (old_v & ~m) | (d & m);
  endfunction

  task automatic model_step();
    bit en, imm, wrap, req, hi;
    int off, r, f;
    logic [31:0] mask;
    if (rst) begin
      model_reset();
      return;
    end
    en = m_ctrl[0];
    imm = m_ctrl[1];
    wrap = en && (m_cnt >= m_per_a);
    for (int c = 0; c < NCH; c++) begin
      r = m_rise_a[c];
      f = m_fall_a[c];
      if (r < f) hi = (m_cnt >= r) && (m_cnt < f);
      else if (r > f) hi = (m_cnt >= r) || (m_cnt < f);
      else hi = 0;
      m_pwm[c] = (en && hi) ^ m_ctrl[16 + c];
      m_rs[c] = en && (m_cnt == r);
      m_fs[c] = en && (m_cnt == f);
    end
    m_irq = wrap;
    req = stb && cyc && !m_ack && (adr >= BASE) && ((adr - BASE) < 32'h50);
    off = int'(adr - BASE);
    m_dat = req ? model_read(off) : 32'h0;
    m_ack = req;
    if (!en || m_cnt >= m_per_a) m_cnt = 0;
    else m_cnt = m_cnt + 1;
    if (wrap || !en || imm) begin
      for (int c = 0; c < NCH; c++) begin
        m_rise_a[c] = m_rise[c];
        m_fall_a[c] = m_fall[c];
      end
      m_per_a = m_per;
    end
    if (wrap) m_status = 1;
    else if (req && we && off / 4 == 18 && sel[0] && dat_i[0]) m_status = 0;
    if (req && we) begin
      mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
      if (off < 64) begin
        int c = off / 8;
        if (c < NCH) begin
          if (off % 8 < 4) m_rise[c] = int'(merge(32'(m_rise[c]), dat_i, mask) & WMASK);
          else m_fall[c] = int'(merge(32'(m_fall[c]), dat_i, mask) & WMASK);
        end
      end else if (off / 4 == 16) begin
        m_ctrl = merge(m_ctrl, dat_i, mask) & CMASK;
      end else if (off / 4 == 17) begin
        m_per = int'(merge(32'(m_per), dat_i, mask) & WMASK);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("outputs", {pwm, rs, fs, irq, ack}, {m_pwm, m_rs, m_fs, m_irq, m_ack});
    if (m_ack) check("rdata", dat_o, m_dat);
    acc0 += int'(pwm[0]);
    acc1 += int'(pwm[1]);
    if (irq) begin
      q0.push_back(acc0);
      q1.push_back(acc1);
      acc0 = 0;
      acc1 = 0;
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] rd, output bit acked);
    adr = a; we = w; sel = s; dat_i = d; stb = 1; cyc = 1;
    acked = 0; rd = 0;
    for (int i = 0; i < 4 && !acked; i++) begin
      tick();
      if (ack) begin
        acked = 1;
        rd = dat_o;
      end
    end
    stb = 0; cyc = 0; we = 0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    logic [31:0] rd;
    bit ak;
    xfer(BASE + off, 1'b1, 4'hF, d, rd, ak);
    check($sformatf("wr_ack_%0h", off), ak, 1);
  endtask

  task automatic rd_chk(input logic [31:0] off, input logic [31:0] want);
    logic [31:0] rd;
    bit ak;
    xfer(BASE + off, 1'b0, 4'hF, 32'h0, rd, ak);
    check($sformatf("rd_ack_%0h", off), ak, 1);
    check($sformatf("rd_%0h", off), rd, want);
  endtask

  task automatic wait_irq();
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      seen = irq;
    end
    check("wait_irq", seen, 1);
  endtask

  task automatic wait_q0(input int n);
    for (int i = 0; i < 100 && q0.size() < n; i++) tick();
    check("wait_periods", q0.size() >= n, 1);
  endtask

  typedef struct {
    logic [31:0] off;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NV = 21;
  vec_t vt[NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdv, d;
    bit ak;
    int hi, nirq, ri, fi, i1, i2, wi;
    logic [2:0] apat;
    logic [8:0] ipat;
    logic [3:0] sel_r;
    logic we_r;

    vt[0]  = '{32'h4C, 1'b0, 4'hF, 32'h0,         1'b1, 32'hAA55_3311};
    vt[1]  = '{32'h50, 1'b1, 4'hF, 32'h1234,      1'b0, 32'h0};
    vt[2]  = '{32'h50, 1'b0, 4'hF, 32'h0,         1'b0, 32'h0};
    vt[3]  = '{32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0,  1'b0, 32'h0};
    vt[4]  = '{32'h00, 1'b1, 4'h1, 32'hFFFF_FF33, 1'b1, 32'h0};
    vt[5]  = '{32'h00, 1'b0, 4'hF, 32'h0,         1'b1, 32'h33};
    vt[6]  = '{32'h04, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vt[7]  = '{32'h04, 1'b0, 4'hF, 32'h0,         1'b1, 32'hFF};
    vt[8]  = '{32'h44, 1'b1, 4'h2, 32'h0000_0500, 1'b1, 32'h0};
    vt[9]  = '{32'h44, 1'b0, 4'hF, 32'h0,         1'b1, 32'hFF};
    vt[10] = '{32'h44, 1'b1, 4'h1, 32'h0000_00AB, 1'b1, 32'h0};
    vt[11] = '{32'h44, 1'b0, 4'hF, 32'h0,         1'b1, 32'hAB};
    vt[12] = '{32'h40, 1'b1, 4'hF, 32'hFFFF_FFFC, 1'b1, 32'h0};
    vt[13] = '{32'h40, 1'b0, 4'hF, 32'h0,         1'b1, 32'h000F_0000};
    vt[14] = '{32'h20, 1'b1, 4'hF, 32'h55,        1'b1, 32'h0};
    vt[15] = '{32'h20, 1'b0, 4'hF, 32'h0,         1'b1, 32'h0};
    vt[16] = '{32'h18, 1'b1, 4'hF, 32'h1234,      1'b1, 32'h0};
    vt[17] = '{32'h18, 1'b0, 4'hF, 32'h0,         1'b1, 32'h34};
    vt[18] = '{32'h48, 1'b0, 4'hF, 32'h0,         1'b1, 32'h0};
    vt[19] = '{32'h40, 1'b1, 4'hF, 32'h0,         1'b1, 32'h0};
    vt[20] = '{32'h3C, 1'b0, 4'hF, 32'h0,         1'b1, 32'h0};

    rst = 1; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; dat_i = 0;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    rst = 0;
    check("reset_outs", {pwm, rs, fs, irq, ack, dat_o}, 64'h0);
    rd_chk(32'h44, 32'hFF);

    // register/bus vectors
    for (int i = 0; i < NV; i++) begin
      xfer(BASE + vt[i].off, vt[i].we, vt[i].sel, vt[i].dat, rdv, ak);
      check($sformatf("vec%0d_ack", i), ak, vt[i].exp_ack);
      if (!vt[i].we && vt[i].exp_ack) check($sformatf("vec%0d_rd", i), rdv, vt[i].exp_rd);
      tick();
    end

    // ack is a single-cycle pulse even with the strobe held
    adr = BASE + 32'h4C; we = 0; sel = 4'hF; stb = 1; cyc = 1;
    tick(); apat[2] = ack;
    tick(); apat[1] = ack;
    tick(); apat[0] = ack;
    stb = 0; cyc = 0;
    tick();
    check("ack_pulse", apat, 3'b101);

    // basic PWM: period 10, high 2..5
    wr(32'h44, 9); wr(32'h00, 2); wr(32'h04, 6); wr(32'h40, 1);
    repeat (3) tick();
    hi = 0; nirq = 0; ri = -1; fi = -1; i1 = -1; i2 = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      hi += int'(pwm[0]);
      if (irq) begin
        nirq++;
        if (i1 < 0) i1 = i;
        else if (i2 < 0) i2 = i;
      end
      if (rs[0] && ri < 0) ri = i;
      if (fs[0] && ri >= 0 && fi < 0) fi = i;
    end
    check("basic_high", hi, 12);
    check("basic_irqs", nirq, 3);
    check("basic_strobe_gap", fi - ri, 4);
    check("basic_irq_gap", i2 - i1, 10);

    // wrap-around pulse on channel 1
    wr(32'h08, 8); wr(32'h0C, 3);
    repeat (12) tick();
    hi = 0; wi = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      hi += int'(pwm[1]);
      if (irq) wi += int'(pwm[1]);
    end
    check("wrap_high", hi, 15);
    check("wrap_at_irq_high", wi, 3);
    wr(32'h08, 5); wr(32'h0C, 5);
    repeat (12) tick();
    hi = 0;
    for (int i = 0; i < 20; i++) begin tick(); hi += int'(pwm[1]); end
    check("equal_low", hi, 0);
    wr(32'h40, 32'h0002_0001);
    repeat (2) tick();
    hi = 0;
    for (int i = 0; i < 20; i++) begin tick(); hi += int'(pwm[1]); end
    check("equal_inverted", hi, 20);
    wr(32'h40, 1);

    // double buffering: mid-period write
    wait_irq();
    q0.delete();
    wr(32'h04, 8);
    wait_q0(2);
    check("dbuf_cur", q0[0], 4);
    check("dbuf_next", q0[1], 6);

    // write landing exactly on the wrap edge
    wait_irq();
    repeat (9) tick();
    q0.delete();
    wr(32'h04, 4);
    wait_q0(3);
    check("wrapedge_end", q0[0], 6);
    check("wrapedge_old", q0[1], 6);
    check("wrapedge_new", q0[2], 2);

    // STATUS sticky and W1C
    rd_chk(32'h48, 1);
    wr(32'h40, 0);
    rd_chk(32'h48, 1);
    wr(32'h48, 1);
    rd_chk(32'h48, 0);

    // reset mid-period overrides a bus write
    wr(32'h40, 1);
    repeat (4) tick();
    rst = 1; adr = BASE + 32'h44; we = 1; sel = 4'hF; dat_i = 5; stb = 1; cyc = 1;
    tick();
    rst = 0; stb = 0; cyc = 0; we = 0;
    check("rst_outs", {pwm, rs, fs, irq, ack}, 64'h0);
    rd_chk(32'h44, 32'hFF);
    rd_chk(32'h40, 32'h0);
    rd_chk(32'h00, 32'h0);

    // immediate mode shrink of PERIOD while count is above it
    wr(32'h00, 2); wr(32'h04, 6); wr(32'h44, 9); wr(32'h40, 3);
    wait_irq();
    repeat (7) tick();
    wr(32'h44, 3);
    for (int i = 0; i < 9; i++) begin tick(); ipat[i] = irq; end
    check("imm_irq_pattern", ipat, 9'h022);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      wi = $urandom_range(0, 23);
      we_r = 1'($urandom_range(0, 1));
      sel_r = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      d = $urandom;
      if (wi == 16) d[0] = ($urandom_range(0, 3) != 0);
      else if (wi < 16 || wi == 17) d[7:0] = 8'($urandom_range(0, 20));
      xfer(BASE + 32'(wi * 4), we_r, sel_r, d, rdv, ak);
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 99) == 0) begin
        rst = 1;
        tick();
        rst = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
